// File: rtl/tbus_arbiter.sv
// tbus_arbiter: round-robin arbiter sharing the single tbus channel between ifu and lsu.
// One outstanding transaction; flush cancels an ifu transaction's completion, not its bus cycle.
module tbus_arbiter #(
    parameter int ADDR_W   = 64,
    parameter int DATA_W   = 64,
    parameter int MASK_W   = 64,
    parameter int OPTYPE_W = 2
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                ifu_index_valid,
    output logic                ifu_index_ready,
    input  logic [ADDR_W-1:0]   ifu_index,
    input  logic [DATA_W-1:0]   ifu_write_data,
    input  logic [MASK_W-1:0]   ifu_write_mask,
    input  logic [OPTYPE_W-1:0] ifu_operation_type,
    output logic [DATA_W-1:0]   ifu_read_data,
    output logic                ifu_operation_done,
    input  logic                ifu_flush,
    input  logic                lsu_index_valid,
    output logic                lsu_index_ready,
    input  logic [ADDR_W-1:0]   lsu_index,
    input  logic [DATA_W-1:0]   lsu_write_data,
    input  logic [MASK_W-1:0]   lsu_write_mask,
    input  logic [OPTYPE_W-1:0] lsu_operation_type,
    output logic [DATA_W-1:0]   lsu_read_data,
    output logic                lsu_operation_done,
    output logic                tbus_index_valid,
    input  logic                tbus_index_ready,
    output logic [ADDR_W-1:0]   tbus_index,
    output logic [DATA_W-1:0]   tbus_write_data,
    output logic [MASK_W-1:0]   tbus_write_mask,
    output logic [OPTYPE_W-1:0] tbus_operation_type,
    input  logic [DATA_W-1:0]   tbus_read_data,
    input  logic                tbus_operation_done,
    output logic                tbus_busy,
    output logic                tbus_owner
);
    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;
    state_t state;
    logic owner, rr_ptr, killed;
    logic ifu_req, grant_ifu, grant_lsu, kill_now, done_ok;
    // owner/rr_ptr encoding: 1 = ifu, 0 = lsu
    assign ifu_req   = ifu_index_valid & ~ifu_flush;
    assign grant_ifu = (state == IDLE) & ifu_req & (~lsu_index_valid | rr_ptr);
    assign grant_lsu = (state == IDLE) & lsu_index_valid & (~ifu_req | ~rr_ptr);
    assign kill_now  = (state != IDLE) & owner & ifu_flush;
    assign done_ok   = (state == RESP) & tbus_operation_done & ~killed & ~kill_now;
    assign ifu_index_ready    = grant_ifu;
    assign lsu_index_ready    = grant_lsu;
    assign ifu_operation_done = done_ok & owner;
    assign lsu_operation_done = done_ok & ~owner;
    assign ifu_read_data      = ifu_operation_done ? tbus_read_data : '0;
    assign lsu_read_data      = lsu_operation_done ? tbus_read_data : '0;
    assign tbus_index_valid   = state == REQ;
    assign tbus_busy          = state != IDLE;
    assign tbus_owner         = owner;
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state               <= IDLE;
            owner               <= 1'b0;
            rr_ptr              <= 1'b0;
            killed              <= 1'b0;
            tbus_index          <= '0;
            tbus_write_data     <= '0;
            tbus_write_mask     <= '0;
            tbus_operation_type <= '0;
        end else begin
            if (grant_ifu | grant_lsu) begin
                state               <= REQ;
                owner               <= grant_ifu;
                killed              <= 1'b0;
                tbus_index          <= grant_ifu ? ifu_index : lsu_index;
                tbus_write_data     <= grant_ifu ? ifu_write_data : lsu_write_data;
                tbus_write_mask     <= grant_ifu ? ifu_write_mask : lsu_write_mask;
                tbus_operation_type <= grant_ifu ? ifu_operation_type : lsu_operation_type;
            end
            if (kill_now)
                killed <= 1'b1;
            if (state == REQ && tbus_index_ready)
                state <= RESP;
            if (state == RESP && tbus_operation_done) begin
                state  <= IDLE;
                rr_ptr <= ~owner;
            end
        end
    end
endmodule
